qpsk_mapper: RTL and testbench
==============================

Name: qpsk_mapper

Overview:
Downstream consumer of the 2-bit I/Q symbol stream from the test symbol source. Maps each 2-bit symbol to a 12-bit I / 12-bit Q two's-complement constellation point. Repeats each point SAMPLES_PER_SYM times, giving a rectangular-pulse baseband sample stream. Output is packed as 24 bits {I,Q} for the DAC/TX path. Both sides use valid/ready streaming.

Parameters:
SAMPLES_PER_SYM, 4, output samples per input symbol; legal range 1..255.
AMP, 1448, constellation magnitude per axis; 12-bit positive value, about 0.707 * 2047.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
in_valid  in  1  symbol stream valid.
in_data  in  2  symbol; [1] = I bit, [0] = Q bit.
in_ready  out  1  mapper accepts a symbol on this cycle.
out_valid  out  1  sample stream valid.
out_data  out  24  {I[11:0], Q[11:0]}, two's complement.
out_ready  in  1  downstream accepts the sample.

Behaviour:
- Reset (rst==0 at a clk edge):
  - out_valid=0, out_data=24'h0.
  - Repeat counter cnt=0; busy=0.
  - Differential accumulator = 0 (when QPSK_DIFF_EN is defined).
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Non-differential axis mapping: bit 0 -> +AMP, bit 1 -> -AMP (12-bit two's complement).
  - Symbol 00 -> 24'h5A8_5A8.
  - Symbol 11 -> 24'hA58_A58.
  - Symbol 10 -> 24'hA58_5A8.
  - Symbol 01 -> 24'h5A8_A58.
- States: IDLE (busy=0) and SEND (busy=1).
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_fire: register the mapped point into out_data, set cnt=0, go to SEND.
  - Latency: the point appears with out_valid=1 on the cycle after acceptance.
- SEND:
  - out_valid=1 and out_data held stable until out_fire (AXIS rule: no change while valid & !ready).
  - On out_fire with cnt < SAMPLES_PER_SYM-1: cnt increments.
  - On out_fire with cnt == SAMPLES_PER_SYM-1 (last repeat):
    - If in_fire the same cycle: load the new point, cnt=0, stay in SEND. This is back-to-back with no bubble.
    - Otherwise: go to IDLE; out_valid=0; out_data holds its last value.
- in_ready = !busy | (out_ready & (cnt == SAMPLES_PER_SYM-1)).
  - This is a combinational path from out_ready; it is accepted.
- in_ready is 0 during SEND except on the last-repeat cycle with out_ready=1.
- SAMPLES_PER_SYM=1: cnt is always 0; sustains one symbol per clock while out_ready stays high.
- out_ready low on the last repeat: in_ready=0 and the output holds. No symbol is lost or duplicated.
- in_valid is ignored when in_ready=0.
- in_data is don't-care when in_valid=0.
- Reset mid-burst: remaining repeats are discarded. Outputs return to reset values on the next edge.

Optional Feature:
Macro QPSK_DIFF_EN: differential Gray-coded encoding.
- Defined:
  - Gray phase-step mapping: 00 -> 0, 10 -> 1, 11 -> 2, 01 -> 3.
  - 2-bit accumulator acc updates on in_fire: acc <= acc + step (mod 4).
  - Output point is the quadrant of the new acc: 0 = (+,+), 1 = (-,+), 2 = (-,-), 3 = (+,-).
  - acc resets to 0.
- Not defined: direct mapping as above; no accumulator logic is synthesised.

Test Plan:
1. Reset check: hold rst=0 for 3 cycles -> out_valid=0, out_data=0, in_ready=1. Release rst -> still idle.
2. Single symbol, SAMPLES_PER_SYM=4, out_ready=1: in_data=00 -> exactly 4 beats of 24'h5A8_5A8 starting the cycle after acceptance. in_ready=0 for beats 1-3. Then out_valid=0.
3. Back-to-back, SAMPLES_PER_SYM=1, continuous in_valid: symbols 00,11,10,01 -> 5A8_5A8, A58_A58, A58_5A8, 5A8_A58 on consecutive cycles with no bubbles.
4. Backpressure, SAMPLES_PER_SYM=4: symbol 11, out_ready toggled 1,0,0,1,1,0,1 -> exactly 4 A58_A58 beats. out_data stays stable while stalled. in_ready asserts only when the 4th beat fires.
5. Reset mid-burst: after 2 of 4 beats, pulse rst=0 for one cycle -> out_valid=0 next edge. The next symbol starts a fresh 4-beat burst.
6. QPSK_DIFF_EN, SAMPLES_PER_SYM=1: symbols 10,10,11,00 -> acc 1,2,0,0 -> A58_5A8, A58_A58, 5A8_5A8, 5A8_5A8.

Source files
------------

// File: rtl/qpsk_mapper.sv
// qpsk_mapper: maps 2-bit I/Q symbols to 12-bit two's-complement QPSK points
// and repeats each point SAMPLES_PER_SYM times as a rectangular-pulse
// baseband stream packed as {I[11:0], Q[11:0]}. Valid/ready on both sides.
// Optional macro QPSK_DIFF_EN selects differential Gray-coded encoding, in
// which the input symbol is a phase step added to a 2-bit accumulator.
module qpsk_mapper #(
  parameter int          SAMPLES_PER_SYM = 4,
  parameter logic [11:0] AMP             = 12'd1448
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [23:0] out_data,
  input  logic        out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [7:0]  LAST_CNT = 8'(SAMPLES_PER_SYM - 1);
  localparam logic [11:0] AMP_NEG  = ~AMP + 12'd1;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [23:0] out_data_q, out_data_d;
  logic [23:0] point;
  logic        last_beat;
  logic        in_fire;
  logic        out_fire;

  // An axis bit of 1 means the negative amplitude.
  function automatic logic [11:0] axis_level(input logic neg);
    return neg ? AMP_NEG : AMP;
  endfunction

  assign last_beat = (cnt_q == LAST_CNT);
  assign out_valid = (state_q == SEND);
  // Accepting on the last repeat's fire lets bursts run back-to-back.
  assign in_ready  = (state_q == IDLE) | (out_ready & last_beat);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_data_q;

`ifdef QPSK_DIFF_EN
  logic [1:0] acc_q, acc_d, phase_step;

  // Gray-coded phase step, then advance the accumulated phase on each accept.
  always_comb begin
    phase_step = 2'd0;
    case (in_data)
      2'b00:   phase_step = 2'd0;
      2'b10:   phase_step = 2'd1;
      2'b11:   phase_step = 2'd2;
      2'b01:   phase_step = 2'd3;
      default: phase_step = 2'd0;
    endcase
    acc_d = acc_q;
    if (in_fire) begin
      acc_d = acc_q + phase_step;
    end
  end

  // Quadrant of the new phase: 0=(+,+) 1=(-,+) 2=(-,-) 3=(+,-).
  always_comb begin
    point = {axis_level(acc_d[1] ^ acc_d[0]), axis_level(acc_d[1])};
  end

  // Phase accumulator register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= 2'd0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  // Direct mapping: I from bit 1, Q from bit 0.
  always_comb begin
    point = {axis_level(in_data[1]), axis_level(in_data[0])};
  end
`endif

  // Next-state logic: load a point on accept, count repeats as they fire.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          out_data_d = point;
          cnt_d      = 8'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (!last_beat) begin
            cnt_d = cnt_q + 8'd1;
          end else if (in_fire) begin
            out_data_d = point;
            cnt_d      = 8'd0;
          end else begin
            cnt_d   = 8'd0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, repeat counter and output sample registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      out_data_q <= 24'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_qpsk_mapper.sv
// tb_qpsk_mapper: drives a 4-sample-per-symbol and a 1-sample-per-symbol
// mapper side by side. A reference model treats each mapper as a queue of
// pending output samples (each accepted symbol contributes SPS copies of its
// constellation point); every cycle it predicts out_valid, out_data and
// in_ready. Build with QPSK_DIFF_EN defined to exercise differential mode.
module tb_qpsk_mapper;

  localparam int SPS4 = 4;
  localparam int SPS1 = 1;
  localparam int AMP  = 1448;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [1:0]  in_data4;
  logic [23:0] out_data4;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [1:0]  in_data1;
  logic [23:0] out_data1;

  int compared   = 0;
  int mismatched = 0;

  logic [23:0] q4[$];
  logic [23:0] q1[$];
  logic [23:0] last4, last1;
  int          phase4, phase1;
  bit          in_fire4, out_fire4, in_fire1, out_fire1;

  always #5 clk = ~clk;

  qpsk_mapper #(.SAMPLES_PER_SYM(SPS4), .AMP(12'd1448)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4)
  );

  qpsk_mapper #(.SAMPLES_PER_SYM(SPS1), .AMP(12'd1448)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1)
  );

  task automatic compare(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference point for a symbol, advancing the phase in differential mode.
  task automatic next_point(input logic [1:0] sym, input int phase_in,
                            output int phase_out, output logic [23:0] pt);
    int  i_val, q_val, stp;
    bit  i_neg, q_neg;
`ifdef QPSK_DIFF_EN
    case (sym)
      2'b00:   stp = 0;
      2'b10:   stp = 1;
      2'b11:   stp = 2;
      default: stp = 3;
    endcase
    phase_out = (phase_in + stp) % 4;
    i_neg = (phase_out == 1) || (phase_out == 2);
    q_neg = (phase_out >= 2);
`else
    stp       = 0;
    phase_out = phase_in + stp;
    i_neg     = sym[1];
    q_neg     = sym[0];
`endif
    i_val = i_neg ? -AMP : AMP;
    q_val = q_neg ? -AMP : AMP;
    pt = {12'(i_val), 12'(q_val)};
  endtask

  task automatic checkOutput();
    bit exp_ready4, exp_ready1;
    exp_ready4 = (q4.size() == 0) || (q4.size() == 1 && out_ready4);
    exp_ready1 = (q1.size() == 0) || (q1.size() == 1 && out_ready1);
    compare("dut4_out_valid", {23'b0, out_valid4}, {23'b0, q4.size() != 0});
    compare("dut4_out_data", out_data4, (q4.size() != 0) ? q4[0] : last4);
    compare("dut4_in_ready", {23'b0, in_ready4}, {23'b0, exp_ready4});
    compare("dut1_out_valid", {23'b0, out_valid1}, {23'b0, q1.size() != 0});
    compare("dut1_out_data", out_data1, (q1.size() != 0) ? q1[0] : last1);
    compare("dut1_in_ready", {23'b0, in_ready1}, {23'b0, exp_ready1});
    in_fire4  = in_valid4 && exp_ready4;
    out_fire4 = (q4.size() != 0) && out_ready4;
    in_fire1  = in_valid1 && exp_ready1;
    out_fire1 = (q1.size() != 0) && out_ready1;
  endtask

  task automatic updateModel();
    logic [23:0] pt;
    if (!rst) begin
      q4.delete();
      q1.delete();
      last4  = 24'h0;
      last1  = 24'h0;
      phase4 = 0;
      phase1 = 0;
    end else begin
      if (out_fire4) void'(q4.pop_front());
      if (in_fire4) begin
        next_point(in_data4, phase4, phase4, pt);
        repeat (SPS4) q4.push_back(pt);
        last4 = pt;
      end
      if (out_fire1) void'(q1.pop_front());
      if (in_fire1) begin
        next_point(in_data1, phase1, phase1, pt);
        repeat (SPS1) q1.push_back(pt);
        last1 = pt;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then step the model.
  task automatic applyStimulus(input logic r,
                               input logic v4, input logic [1:0] d4, input logic o4,
                               input logic v1, input logic [1:0] d1, input logic o1);
    rst        = r;
    in_valid4  = v4;
    in_data4   = d4;
    out_ready4 = o4;
    in_valid1  = v1;
    in_data1   = d1;
    out_ready1 = o1;
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  logic [1:0]  tbl_sym[4];
  logic [23:0] tbl_pt[4];
  logic        bp_ready[7];

  initial begin
`ifdef QPSK_DIFF_EN
    tbl_sym = '{2'b10, 2'b10, 2'b11, 2'b00};
    tbl_pt  = '{24'hA58_5A8, 24'hA58_A58, 24'h5A8_5A8, 24'h5A8_5A8};
`else
    tbl_sym = '{2'b00, 2'b11, 2'b10, 2'b01};
    tbl_pt  = '{24'h5A8_5A8, 24'hA58_A58, 24'hA58_5A8, 24'h5A8_A58};
`endif
    bp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    last4 = 24'h0;
    last1 = 24'h0;
    phase4 = 0;
    phase1 = 0;

    // Reset held low for three cycles.
    rst = 1'b0;
    in_valid4 = 1'b0; in_data4 = 2'b00; out_ready4 = 1'b1;
    in_valid1 = 1'b0; in_data1 = 2'b00; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare("reset_out_valid4", {23'b0, out_valid4}, 24'h0);
    compare("reset_out_data4", out_data4, 24'h0);
    compare("reset_in_ready4", {23'b0, in_ready4}, 24'h1);
    compare("reset_out_valid1", {23'b0, out_valid1}, 24'h0);
    compare("reset_out_data1", out_data1, 24'h0);
    compare("reset_in_ready1", {23'b0, in_ready1}, 24'h1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);

    // One sample per symbol, back-to-back accepts with no bubbles.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, tbl_sym[k], 1'b1);
      compare("b2b_valid", {23'b0, out_valid1}, 24'h1);
      compare("b2b_point", out_data1, tbl_pt[k]);
    end
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);

    // Single symbol 00 on the 4x mapper, downstream always ready.
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    compare("single_first_valid", {23'b0, out_valid4}, 24'h1);
    compare("single_first_point", out_data4, 24'h5A8_5A8);
    repeat (5) applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);

    // Backpressure on symbol 11; in_valid held high while stalled.
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, (k < 6), 2'($urandom), bp_ready[k], 1'b0, 2'b00, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);

    // Reset in the middle of a burst, then a fresh burst.
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    compare("midburst_reset_valid", {23'b0, out_valid4}, 24'h0);
    compare("midburst_reset_data", out_data4, 24'h0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);

    // Randomised traffic with occasional resets and frequent backpressure.
    repeat (600) begin
      applyStimulus(($urandom % 60) != 0,
                    1'($urandom), 2'($urandom), ($urandom % 4) != 0,
                    1'($urandom), 2'($urandom), ($urandom % 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
